// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEADBEEF;
  localparam int          WAIT_CNT_W    = 4;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, registered read. Contents are never cleared.
module dmem_array #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 32
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clock) begin
    if (we) mem[index] <= wdata;
    if (re) rdata <= mem[index];
  end

endmodule

// File: rtl/dmem_wait_responder.sv
// MEM-stage data memory with a fixed number of wait states and a pipeline stall.
// Optional address/request checking is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_wait_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata
`ifdef DMEM_ERR_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam logic [WAIT_CNT_W-1:0] CNT_INIT = WAIT_CNT_W'(WAIT_CYCLES - 1);

  dmem_state_e             state;
  dmem_state_e             state_next;
  logic [WAIT_CNT_W-1:0]   cnt;
  logic [DEPTH_LOG2-1:0]   lat_index;
  logic [DATA_W-1:0]       lat_wdata;
  logic                    lat_write;
  logic                    lat_fault;
  logic                    rd_valid;
  logic                    rd_fault;
  logic                    req_any;
  logic                    req_fault;
  logic                    done_edge;
  logic                    arr_we;
  logic                    arr_re;
  logic [DATA_W-1:0]       arr_rdata;

  assign req_any   = req_read | req_write;
  assign done_edge = (state == WAIT) && (cnt == '0);
  assign arr_we    = done_edge && lat_write && !lat_fault;
  assign arr_re    = done_edge && !lat_write && !lat_fault;
  assign rsp_ready = (state == DONE);

`ifdef DMEM_ERR_CHECK_EN
  assign req_fault = (req_addr[1:0] != 2'b00) ||
                     (req_addr[31:DEPTH_LOG2+2] != '0) ||
                     (req_read && req_write);

  // Sticky until reset; set on the edge that enters DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err <= 1'b0;
    else if (done_edge && lat_fault) err <= 1'b1;
  end
`else
  logic unused_addr_bits;
  assign req_fault        = 1'b0;
  assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
`endif

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          stall      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == '0) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Requests are latched only at IDLE sampling; later input changes are ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_index <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      lat_fault <= 1'b0;
      rd_valid  <= 1'b0;
      rd_fault  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_any) begin
        cnt       <= CNT_INIT;
        lat_index <= req_addr[DEPTH_LOG2+1:2];
        lat_wdata <= req_wdata;
        lat_write <= req_write;
        lat_fault <= req_fault;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (done_edge && !lat_write) begin
        rd_valid <= 1'b1;
        rd_fault <= lat_fault;
      end
    end
  end

  // The array's read register has no reset, so gate it until a read completes.
  assign rsp_rdata = !rd_valid ? '0 :
                     rd_fault  ? DATA_W'(DMEM_ERR_DATA) : arr_rdata;

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_array (
    .clock (clock),
    .we    (arr_we),
    .re    (arr_re),
    .index (lat_index),
    .wdata (lat_wdata),
    .rdata (arr_rdata)
  );

endmodule
